apb_slave_interface_ws: RTL and testbench
=========================================

# apb_slave_interface_ws

Parametrised APB4 slave front-end between the peripheral APB bus and a block's register file. It decodes word-aligned register addresses into one-hot write/read strobes and forwards byte strobes. It supports optional register-side wait states with a timeout, and per-register read-only/write-only access checks that raise PSLVERR. Zero-wait transfers complete in the minimum two-cycle APB setup/access sequence.

## Interface
- NUM_REGS, 4: number of 32-bit registers, at least 1.
- ADDR_OFFSET, 12'h000: byte address of register 0 within the decoded window.
- ADDR_BITS, 12: low PADDR bits compared; higher bits are ignored.
- RO_MASK, 0 (NUM_REGS bits): bit i set means register i is read-only; a write to it is an error.
- WO_MASK, 0 (NUM_REGS bits): bit i set means register i is write-only; a read of it is an error.
- WAIT_EN, 0: 1 means completion waits for reg_ready.
- TIMEOUT, 16: maximum WAIT cycles before an error completion, at least 2.
- clk  in  1  single clock. One clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high; forces IDLE and zeroes all registered state.
- PADDR  in  32  APB address.
- PWDATA  in  32  write data.
- PSTRB  in  4  write byte strobes.
- PENABLE, PWRITE, PSEL  in  1  APB control.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error, valid only with PREADY.
- read_data  in  NUM_REGS*32  register contents; register i occupies [i*32 +: 32].
- reg_ready  in  1  register side done; used only when WAIT_EN=1.
- w_enable  out  NUM_REGS  one-hot write strobe.
- r_enable  out  NUM_REGS  one-hot read strobe.
- w_data  out  32  equals PWDATA.
- w_strb  out  4  equals PSTRB.

## Operation
- Decode: a hit means PADDR[ADDR_BITS-1:0] == ADDR_OFFSET + 4*i for some i < NUM_REGS.
- The access is illegal when any of these holds:
  - no hit;
  - PADDR[1:0] != 0;
  - a write and RO_MASK[i] set;
  - a read and WO_MASK[i] set.
- States: IDLE, ACCESS, WAIT.
- IDLE:
  - PSEL && !PENABLE latches idx, legal, PWRITE and moves to ACCESS.
  - Otherwise stays in IDLE.
- ACCESS, illegal access:
  - PREADY=1, PSLVERR=1, PRDATA=32'hBAD1BAD1.
  - No strobes. Next state IDLE.
- ACCESS, legal access:
  - Asserts w_enable[idx] (write) or r_enable[idx] (read) for exactly this cycle.
  - A write with PSTRB==0 asserts no w_enable but completes normally.
  - WAIT_EN=0: PREADY=1; on a read, PRDATA=read_data[idx]. Next state IDLE.
  - WAIT_EN=1 and reg_ready=1: completes as for WAIT_EN=0.
  - WAIT_EN=1 and reg_ready=0: PREADY=0, counter cleared, next state WAIT.
- WAIT:
  - No strobes. The counter increments each cycle.
  - reg_ready=1: PREADY=1 with PRDATA=read_data[idx] (read) or 0 (write). Next state IDLE.
  - Counter reaches TIMEOUT-1 without reg_ready: error completion (PREADY=1, PSLVERR=1, PRDATA=32'hBAD1BAD1). Next state IDLE.
- PSEL deasserted in ACCESS or WAIT (protocol violation): abort to IDLE next cycle. No PREADY; no further strobes.
- PSTRB is ignored on reads.
- Outputs outside a completion cycle: PREADY=0, PSLVERR=0, PRDATA=0.

## Timing
- Reset: state IDLE, counter 0. PRDATA, PREADY, PSLVERR, w_enable and r_enable all 0 on the cycle after rst is sampled high. Reset mid-transfer drops the transfer with no PREADY.
- Zero-wait transfer: setup cycle, then an access cycle with PREADY=1. Strobe and PREADY occur in the same cycle.
- Wait-state transfer: PREADY rises in the first cycle reg_ready=1 after the access cycle begins.
- Timeout transfer: error PREADY at access cycle + TIMEOUT.
- Back-to-back: a new setup in the cycle after PREADY is accepted with no idle cycle.
- Decode results are registered at setup. Changes in PADDR during access are ignored.
- PRDATA and PREADY are combinational from state and read_data/reg_ready. Registered state is only state, idx, legal, write and counter.

## Structure
- Package apb_slave_pkg holds:
  - state enum {IDLE, ACCESS, WAIT};
  - ERR_DATA = 32'hBAD1BAD1;
  - BYTES_PER_WORD = 4.
- Sub-module apb_addr_decoder: combinational PADDR/PWRITE to {hit, idx, legal}, parametrised by NUM_REGS, ADDR_OFFSET, ADDR_BITS, RO_MASK, WO_MASK.
- Top module: FSM, timeout counter, output muxing.

## Test plan
- Zero-wait write: NUM_REGS=4, write 0xDEADBEEF to 0x008 with PSTRB=4'hF -> w_enable=4'b0100 for one cycle, w_data=0xDEADBEEF, PREADY=1 in the access cycle, PSLVERR=0.
- Zero-wait read: read 0x00C with read_data[3]=0x12345678 -> r_enable=4'b1000, PRDATA=0x12345678 with PREADY.
- Access errors, each producing PREADY=1, PSLVERR=1, PRDATA=0xBAD1BAD1 and no strobes:
  - read of 0x010 (no hit);
  - read of 0x006 (misaligned);
  - write to register 1 with RO_MASK=4'b0010.
- Wait states: WAIT_EN=1, reg_ready delayed 3 cycles -> strobe only in the access cycle, PREADY low 3 cycles and then high. With TIMEOUT=4 and reg_ready held low -> error completion at access cycle + 4.
- Back-to-back: read 0x000 immediately followed by write 0x004 -> both complete in 4 total cycles.
- Aborts: rst or PSEL drop during WAIT -> state IDLE, no PREADY, all outputs 0.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared state type and constants for the APB slave front-end
package apb_slave_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  localparam logic [31:0] ERR_DATA = 32'hBAD1BAD1;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps PADDR/PWRITE to register hit, index and access legality
module apb_addr_decoder
  import apb_slave_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter logic [31:0] ADDR_OFFSET = 32'h000,
  parameter int ADDR_BITS = 12,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS-1:0] WO_MASK = '0,
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic [31:0]   paddr,
  input  logic          pwrite,
  output logic          hit,
  output logic [IW-1:0] idx,
  output logic          legal
);
  logic ro, wo, unused_hi;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    ro = 1'b0;
    wo = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (paddr[ADDR_BITS-1:0] == ADDR_BITS'(ADDR_OFFSET + 32'(BYTES_PER_WORD * i))) begin
        hit = 1'b1;
        idx = IW'(i);
        ro = RO_MASK[i];
        wo = WO_MASK[i];
      end
  end
  assign legal = hit && paddr[1:0] == 2'b00 && !(pwrite ? ro : wo);
  assign unused_hi = ^(paddr >> ADDR_BITS);
endmodule

// File: rtl/apb_slave_interface_ws.sv
// apb_slave_interface_ws: APB4 slave front-end with register strobes, wait states, timeout and access checks
module apb_slave_interface_ws
  import apb_slave_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter logic [31:0] ADDR_OFFSET = 32'h000,
  parameter int ADDR_BITS = 12,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS-1:0] WO_MASK = '0,
  parameter bit WAIT_EN = 1'b0,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            PADDR,
  input  logic [31:0]            PWDATA,
  input  logic [3:0]             PSTRB,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic                   PSEL,
  output logic [31:0]            PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  input  logic [NUM_REGS*32-1:0] read_data,
  input  logic                   reg_ready,
  output logic [NUM_REGS-1:0]    w_enable,
  output logic [NUM_REGS-1:0]    r_enable,
  output logic [31:0]            w_data,
  output logic [3:0]             w_strb
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_nx;
  logic [IW-1:0] idx, dec_idx;
  logic legal, write, dec_legal, hit_unused;
  logic [CW-1:0] cnt;
  logic [31:0] regs [NUM_REGS];
  logic acc, wt, timeout, ok, err;
  logic [NUM_REGS-1:0] sel;
  apb_addr_decoder #(
    .NUM_REGS(NUM_REGS), .ADDR_OFFSET(ADDR_OFFSET), .ADDR_BITS(ADDR_BITS),
    .RO_MASK(RO_MASK), .WO_MASK(WO_MASK)
  ) u_dec (
    .paddr(PADDR), .pwrite(PWRITE), .hit(hit_unused), .idx(dec_idx), .legal(dec_legal)
  );
  for (genvar k = 0; k < NUM_REGS; k++) assign regs[k] = read_data[k*32 +: 32];
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      legal <= 1'b0;
      write <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && PSEL && !PENABLE) begin
        idx <= dec_idx;
        legal <= dec_legal;
        write <= PWRITE;
      end
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
    end
  always_comb begin
    acc = state == ACCESS && PSEL;
    wt = state == WAIT && PSEL;
    timeout = cnt == CW'(TIMEOUT - 1);
    ok = (acc && legal && (!WAIT_EN || reg_ready)) || (wt && reg_ready);
    err = (acc && !legal) || (wt && !reg_ready && timeout);
    sel = acc && legal ? NUM_REGS'(1) << idx : '0;
    state_nx = state == IDLE ? (PSEL && !PENABLE ? ACCESS : IDLE)
             : acc && legal && WAIT_EN && !reg_ready ? WAIT
             : wt && !reg_ready && !timeout ? WAIT : IDLE;
  end
  assign PREADY = ok || err;
  assign PSLVERR = err;
  assign PRDATA = err ? ERR_DATA : ok && !write ? regs[idx] : '0;
  assign w_enable = write && PSTRB != 4'h0 ? sel : '0;
  assign r_enable = write ? '0 : sel;
  assign w_data = PWDATA;
  assign w_strb = PSTRB;
endmodule

// File: tb/tb_apb_slave_interface_ws.sv
// tb_apb_slave_interface_ws: random and directed APB transfers on zero-wait and wait-state slaves vs a transfer-level model
module tb_apb_slave_interface_ws;
  localparam logic [3:0] RO = 4'b0010;
  localparam logic [3:0] WO = 4'b0100;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0] pstrb = '0;
  logic penable = 1'b0, pwrite = 1'b0, psel = 1'b0, reg_ready = 1'b0;
  logic [31:0] rd [4];
  logic [127:0] read_data;
  logic [1:0][31:0] prdata, w_data;
  logic [1:0] pready, pslverr;
  logic [1:0][3:0] w_enable, r_enable, w_strb;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign read_data = {rd[3], rd[2], rd[1], rd[0]};
  apb_slave_interface_ws #(
    .NUM_REGS(4), .ADDR_OFFSET(32'h000), .ADDR_BITS(12), .RO_MASK(RO), .WO_MASK(WO),
    .WAIT_EN(1'b0), .TIMEOUT(16)
  ) dut0 (
    .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PENABLE(penable),
    .PWRITE(pwrite), .PSEL(psel), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .read_data(read_data), .reg_ready(reg_ready), .w_enable(w_enable[0]), .r_enable(r_enable[0]),
    .w_data(w_data[0]), .w_strb(w_strb[0])
  );
  apb_slave_interface_ws #(
    .NUM_REGS(4), .ADDR_OFFSET(32'h000), .ADDR_BITS(12), .RO_MASK(RO), .WO_MASK(WO),
    .WAIT_EN(1'b1), .TIMEOUT(4)
  ) dut1 (
    .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PENABLE(penable),
    .PWRITE(pwrite), .PSEL(psel), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .read_data(read_data), .reg_ready(reg_ready), .w_enable(w_enable[1]), .r_enable(r_enable[1]),
    .w_data(w_data[1]), .w_strb(w_strb[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d pready", tag, d), 32'(pready[d]), 32'd0);
      chk($sformatf("%s d%0d pslverr", tag, d), 32'(pslverr[d]), 32'd0);
      chk($sformatf("%s d%0d prdata", tag, d), prdata[d], 32'd0);
      chk($sformatf("%s d%0d w_enable", tag, d), 32'(w_enable[d]), 32'd0);
      chk($sformatf("%s d%0d r_enable", tag, d), 32'(r_enable[d]), 32'd0);
    end
  endtask
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, input int rdy, input int abt);
    int a, idx, last, tm;
    int done [2];
    bit ok_addr;
    bit err [2];
    a = int'(addr[11:0]);
    idx = a / 4;
    ok_addr = a % 4 == 0 && a < 16;
    if (ok_addr) ok_addr = !(wr ? RO[idx] : WO[idx]);
    for (int d = 0; d < 2; d++) begin
      tm = d == 1 ? 4 : 16;
      done[d] = (!ok_addr || d == 0) ? 0 : (rdy <= tm ? rdy : tm);
      err[d] = !ok_addr || (d == 1 && rdy > tm);
    end
    last = abt >= 0 ? abt : done[1];
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
    reg_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk_idle("setup");
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      psel = !(abt >= 0 && k >= abt);
      reg_ready = k >= rdy;
      if (k > 0) paddr = $urandom;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        bit fin, strobe;
        logic [3:0] m;
        logic [31:0] ed;
        fin = k == done[d] && (abt < 0 || k < abt);
        strobe = k == 0 && abt != 0 && ok_addr;
        m = 4'b0001 << idx;
        ed = !fin ? 32'd0 : err[d] ? BAD : wr ? 32'd0 : rd[idx];
        chk($sformatf("a%h k%0d d%0d pready", addr[11:0], k, d), 32'(pready[d]), 32'(fin));
        chk($sformatf("a%h k%0d d%0d pslverr", addr[11:0], k, d), 32'(pslverr[d]), 32'(fin && err[d]));
        chk($sformatf("a%h k%0d d%0d prdata", addr[11:0], k, d), prdata[d], ed);
        chk($sformatf("a%h k%0d d%0d w_enable", addr[11:0], k, d), 32'(w_enable[d]),
            32'(strobe && wr && st != 4'h0 ? m : 4'h0));
        chk($sformatf("a%h k%0d d%0d r_enable", addr[11:0], k, d), 32'(r_enable[d]),
            32'(strobe && !wr ? m : 4'h0));
      end
      if (k == 0) begin
        chk("w_data", w_data[0], wd);
        chk("w_strb", 32'(w_strb[1]), 32'(st));
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 4; i++) rd[i] = $urandom;
    rd[3] = 32'h12345678;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    xfer(32'h008, 1'b1, 32'hDEADBEEF, 4'hF, 0, -1);
    xfer(32'h00C, 1'b0, 32'h0, 4'h0, 0, -1);
    xfer(32'h010, 1'b0, 32'h0, 4'h0, 0, -1);
    xfer(32'h006, 1'b0, 32'h0, 4'h0, 0, -1);
    xfer(32'h004, 1'b1, 32'h55AA55AA, 4'hF, 0, -1);
    xfer(32'h008, 1'b0, 32'h0, 4'h0, 0, -1);
    xfer(32'h00C, 1'b1, 32'h11111111, 4'h0, 0, -1);
    xfer(32'h008, 1'b1, 32'hCAFEF00D, 4'h3, 3, -1);
    xfer(32'h00C, 1'b0, 32'h0, 4'h0, 99, -1);
    xfer(32'h00C, 1'b0, 32'h0, 4'h0, 4, -1);
    xfer(32'h000, 1'b0, 32'h0, 4'h0, 0, -1);
    xfer(32'h004, 1'b1, 32'h0, 4'hF, 0, -1);
    xfer(32'hFFFFF00C, 1'b0, 32'h0, 4'h0, 0, -1);
    xfer(32'h00C, 1'b0, 32'h0, 4'h0, 99, 2);
    xfer(32'h000, 1'b1, 32'h12, 4'h1, 0, 0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h00C; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1; reg_ready = 1'b0;
    @(negedge clk);
    chk("rst_abort access r_enable", 32'(r_enable[1]), 32'h8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; reg_ready = 1'b1;
    @(negedge clk);
    chk_idle("rst_abort");
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle("rst_after");
    psel = 1'b0; penable = 1'b0;
    repeat (300) begin
      logic [31:0] addr;
      int abt;
      for (int i = 0; i < 4; i++) rd[i] = $urandom;
      addr = $urandom;
      addr[11:0] = 12'($urandom_range(0, 5) * 4 + ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0));
      abt = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 3)) : -1;
      xfer(addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           int'($urandom_range(0, 6)), abt);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk_idle("gap");
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
